// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: pulls bytes from a UART RX FIFO and reassembles SOF/LEN/payload/CSUM frames.
// Each frame is checked against an XOR checksum. Good payloads are replayed downstream with
// valid/ready handshaking. Bad frames are dropped with an error pulse and an error code.
module uart_pkt_deframer #(
    parameter int unsigned      DBITS          = 8,
    parameter int unsigned      MAX_LEN        = 16,
    parameter logic [DBITS-1:0] SOF            = 8'hA5,
    parameter int unsigned      TIMEOUT_CYCLES = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_empty,
    input  logic [DBITS-1:0] i_rx_data,
    output logic             o_rd_uart,
    output logic [DBITS-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_pkt_ok,
    output logic             o_pkt_err,
    output logic [1:0]       o_err_code,
    output logic             o_busy
);

    localparam int unsigned      IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBITS-1:0] MAX_LEN_B = DBITS'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_EMIT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W-1:0]   len_m1, len_m1_n;
    logic [DBITS-1:0]   csum, csum_n;
    logic [TMO_W-1:0]   tcnt, tcnt_n;
    logic               pkt_ok, pkt_ok_n;
    logic               pkt_err, pkt_err_n;
    logic [1:0]         err_code, err_code_n;
    logic               rd_en;
    logic               buf_we;
    logic               tmo_hit;
    logic [DBITS-1:0]   buf_mem [MAX_LEN];

    // Pop whenever a byte is available, except while replaying a packet.
    assign rd_en     = ~i_rx_empty & (state != ST_EMIT);
    assign o_rd_uart = rd_en & ~i_rst;

    // The timeout fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES.
    // A byte consumed in that same cycle takes priority.
    assign tmo_hit = ((state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM))
                     && !rd_en && (tcnt == TMO_LAST);

    assign o_valid    = (state == ST_EMIT);
    assign o_data     = o_valid ? buf_mem[idx] : '0;
    assign o_last     = o_valid && (idx == len_m1);
    assign o_busy     = (state != ST_HUNT);
    assign o_pkt_ok   = pkt_ok;
    assign o_pkt_err  = pkt_err;
    assign o_err_code = err_code;

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_HUNT;
            idx      <= '0;
            len_m1   <= '0;
            csum     <= '0;
            tcnt     <= '0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 2'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len_m1   <= len_m1_n;
            csum     <= csum_n;
            tcnt     <= tcnt_n;
            pkt_ok   <= pkt_ok_n;
            pkt_err  <= pkt_err_n;
            err_code <= err_code_n;
        end
    end

    // Payload buffer. Its contents do not need a reset.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_mem[idx] <= i_rx_data;
        end
    end

    // Next-state logic: frame parsing, checksum, timeout and replay.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        len_m1_n   = len_m1;
        csum_n     = csum;
        tcnt_n     = '0;
        pkt_ok_n   = 1'b0;
        pkt_err_n  = 1'b0;
        err_code_n = err_code;
        buf_we     = 1'b0;

        if ((state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM)) begin
            tcnt_n = rd_en ? '0 : tcnt + TMO_W'(1);
        end

        if (tmo_hit) begin
            state_n    = ST_HUNT;
            idx_n      = '0;
            tcnt_n     = '0;
            pkt_err_n  = 1'b1;
            err_code_n = 2'd3;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (rd_en && (i_rx_data == SOF)) begin
                        state_n = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rd_en) begin
                        if ((i_rx_data == '0) || (i_rx_data > MAX_LEN_B)) begin
                            state_n    = ST_HUNT;
                            pkt_err_n  = 1'b1;
                            err_code_n = 2'd1;
                        end else begin
                            state_n  = ST_PAYLOAD;
                            len_m1_n = IDX_W'(i_rx_data - DBITS'(1));
                            csum_n   = i_rx_data;
                            idx_n    = '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rd_en) begin
                        buf_we = 1'b1;
                        csum_n = csum ^ i_rx_data;
                        if (idx == len_m1) begin
                            state_n = ST_CSUM;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (rd_en) begin
                        if (i_rx_data == csum) begin
                            state_n  = ST_EMIT;
                            pkt_ok_n = 1'b1;
                        end else begin
                            state_n    = ST_HUNT;
                            pkt_err_n  = 1'b1;
                            err_code_n = 2'd2;
                        end
                    end
                end
                ST_EMIT: begin
                    if (i_ready) begin
                        if (idx == len_m1) begin
                            state_n = ST_HUNT;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// tb_uart_pkt_deframer: directed test of uart_pkt_deframer using a queue-modelled RX FIFO.
// Transfers and pulses are collected by a monitor and checked against expected values
// computed by hand for each packet.
module tb_uart_pkt_deframer;

    localparam int TMO = 20;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx_empty;
    logic [7:0] i_rx_data;
    logic       o_rd_uart;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;
    logic       o_pkt_ok;
    logic       o_pkt_err;
    logic [1:0] o_err_code;
    logic       o_busy;

    uart_pkt_deframer #(
        .DBITS(8),
        .MAX_LEN(16),
        .SOF(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_rx_empty(i_rx_empty),
        .i_rx_data(i_rx_data),
        .o_rd_uart(o_rd_uart),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last(o_last),
        .o_pkt_ok(o_pkt_ok),
        .o_pkt_err(o_pkt_err),
        .o_err_code(o_err_code),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // RX FIFO model: written by the stimulus, popped on the DUT's read strobe.
    logic [7:0] fmem [256];
    int         f_wr = 0;
    int         f_rd = 0;
    assign i_rx_empty = (f_wr == f_rd);
    assign i_rx_data  = fmem[f_rd % 256];

    always @(posedge i_clk) begin
        if (o_rd_uart) f_rd <= f_rd + 1;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] tx[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: samples just after the falling edge, once stimulus changes have settled.
    always @(negedge i_clk) begin
        #1;
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                got_d.push_back(o_data);
                got_l.push_back(o_last);
            end
            if (o_pkt_ok) ok_cnt++;
            if (o_pkt_err) err_cnt++;
            if (o_pkt_ok || o_pkt_err) check_eq("ok_err_excl", 32'(o_pkt_ok & o_pkt_err), 0);
        end
    end

    task automatic push(input logic [7:0] b);
        fmem[f_wr % 256] = b;
        f_wr = f_wr + 1;
    endtask

    task automatic send();
        foreach (tx[i]) push(tx[i]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (((f_rd != f_wr) || o_busy) && (n < 300));
        check_eq({tag, "_done"}, 32'((f_rd != f_wr) || o_busy), 0);
        @(negedge i_clk);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while ((f_rd != f_wr) && (n < 100));
        check_eq({tag, "_empty"}, 32'(f_rd != f_wr), 0);
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_cnt"}, got_d.size(), exp_d.size());
        if (got_d.size() == exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                check_eq($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
                check_eq($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
            end
        end
        got_d.delete();
        got_l.delete();
    endtask

    task automatic check_stats(input string tag, input int e_ok, input int e_err, input int e_code);
        check_eq({tag, "_okcnt"}, ok_cnt, e_ok);
        check_eq({tag, "_errcnt"}, err_cnt, e_err);
        check_eq({tag, "_code"}, 32'(o_err_code), e_code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_rst   = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        push(8'h00);
        #1;
        check_eq("rst_rd", 32'(o_rd_uart), 0);
        check_eq("rst_valid", 32'(o_valid), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_code", 32'(o_err_code), 0);
        check_eq("rst_ok", 32'(o_pkt_ok), 0);
        check_eq("rst_err", 32'(o_pkt_err), 0);
        check_eq("rst_data", 32'(o_data), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_done("pre");

        // Good packet
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send();
        wait_done("good");
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_l = '{1'b0, 1'b0, 1'b1};
        check_rx("good");
        check_stats("good", 1, 0, 0);

        // Bad checksum, then a good packet
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send();
        wait_done("badcs");
        exp_d = {};
        exp_l = {};
        check_rx("badcs");
        check_stats("badcs", 1, 1, 2);
        tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send();
        wait_done("after_badcs");
        exp_d = '{8'h7E};
        exp_l = '{1'b1};
        check_rx("after_badcs");
        check_stats("after_badcs", 2, 1, 2);

        // Bad LEN: zero and MAX_LEN+1
        tx = '{8'hA5, 8'h00};
        send();
        wait_done("len0");
        check_stats("len0", 2, 2, 1);
        check_eq("len0_busy", 32'(o_busy), 0);
        tx = '{8'hA5, 8'h11};
        send();
        wait_done("len17");
        check_stats("len17", 2, 3, 1);
        check_eq("len17_busy", 32'(o_busy), 0);

        // Maximum length: payload 00..0F XORs to 0, so CSUM equals LEN
        tx = '{8'hA5, 8'h10};
        exp_d = {};
        exp_l = {};
        for (int i = 0; i < 16; i++) begin
            tx.push_back(8'(i));
            exp_d.push_back(8'(i));
            exp_l.push_back(i == 15);
        end
        tx.push_back(8'h10);
        send();
        wait_done("maxlen");
        check_rx("maxlen");
        check_stats("maxlen", 3, 3, 1);

        // Garbage ahead of a good packet
        tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
        send();
        wait_done("garbage");
        exp_d = '{8'hC3, 8'h3C};
        exp_l = '{1'b0, 1'b1};
        check_rx("garbage");
        check_stats("garbage", 4, 3, 1);

        // Timeout after a partial payload
        tx = '{8'hA5, 8'h02, 8'h11};
        send();
        wait_empty("tmo");
        repeat (TMO - 1) @(negedge i_clk);
        check_eq("tmo_pre_err", 32'(o_pkt_err), 0);
        check_eq("tmo_pre_busy", 32'(o_busy), 1);
        @(negedge i_clk);
        check_eq("tmo_err", 32'(o_pkt_err), 1);
        check_eq("tmo_code", 32'(o_err_code), 3);
        check_eq("tmo_busy", 32'(o_busy), 0);
        wait_done("tmo");
        check_stats("tmo", 4, 4, 3);

        // Byte arriving on the limit cycle cancels the timeout
        tx = '{8'hA5, 8'h02, 8'h11};
        send();
        wait_empty("save");
        repeat (TMO - 1) @(negedge i_clk);
        push(8'h22);
        push(8'h31);
        @(negedge i_clk);
        check_eq("save_err", 32'(o_pkt_err), 0);
        check_eq("save_busy", 32'(o_busy), 1);
        wait_done("save");
        exp_d = '{8'h11, 8'h22};
        exp_l = '{1'b0, 1'b1};
        check_rx("save");
        check_stats("save", 5, 4, 3);

        // Backpressure in EMIT with the next packet already waiting in the FIFO
        begin
            int n = 0;
            i_ready = 1'b0;
            tx = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD, 8'hA5};
            send();
            do begin
                @(negedge i_clk);
                n++;
            end while (!o_valid && (n < 50));
            check_eq("bp_valid_seen", 32'(o_valid), 1);
            for (int i = 0; i < 20; i++) begin
                check_eq("bp_data", 32'(o_data), 32'hAA);
                check_eq("bp_last", 32'(o_last), 0);
                check_eq("bp_rd", 32'(o_rd_uart), 0);
                @(negedge i_clk);
            end
            check_eq("bp_fifo_pending", 32'(i_rx_empty), 0);
            i_ready = 1'b1;
            tx = '{8'h01, 8'h5A, 8'h5B};
            send();
            wait_done("bp");
            exp_d = '{8'hAA, 8'h55, 8'h5A};
            exp_l = '{1'b0, 1'b1, 1'b1};
            check_rx("bp");
            check_stats("bp", 7, 4, 3);
        end

        // Reset during PAYLOAD
        tx = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send();
        wait_empty("mid");
        check_eq("mid_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        push(8'h00);
        #1;
        check_eq("mid_rst_busy", 32'(o_busy), 0);
        check_eq("mid_rst_rd", 32'(o_rd_uart), 0);
        check_eq("mid_rst_valid", 32'(o_valid), 0);
        check_eq("mid_rst_err", 32'(o_pkt_err), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_done("mid");
        exp_d = {};
        exp_l = {};
        check_rx("mid");
        check_stats("mid", 7, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_pkt_deframer.md
UART_PKT_DEFRAMER -- requirements
Module: uart_pkt_deframer

Interface
REQ-001 SHALL have parameter DBITS, 8, byte width; must match the UART data width.
REQ-002 SHALL have parameter MAX_LEN, 16, maximum payload bytes per packet (1..255).
REQ-003 SHALL have parameter SOF, 8'hA5, start-of-frame byte.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 100000, idle i_clk cycles allowed between bytes inside a packet.
REQ-005 SHALL have port i_clk input 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port i_rst input 1: reset, asynchronous, active-high.
REQ-007 SHALL have port i_rx_empty input 1: UART RX FIFO empty.
REQ-008 SHALL have port i_rx_data input DBITS: RX FIFO head byte, valid whenever i_rx_empty=0.
REQ-009 SHALL have port o_rd_uart output 1: pop strobe; the head byte is consumed in any cycle where it is 1.
REQ-010 SHALL have port o_data output DBITS: payload byte out.
REQ-011 SHALL have port o_valid output 1: o_data valid.
REQ-012 SHALL have port i_ready input 1: downstream accepts; transfer = o_valid & i_ready.
REQ-013 SHALL have port o_last output 1: marks the final payload byte (qualified by o_valid).
REQ-014 SHALL have port o_pkt_ok output 1: one-cycle pulse on a good packet.
REQ-015 SHALL have port o_pkt_err output 1: one-cycle pulse on a dropped packet.
REQ-016 SHALL have port o_err_code output 2: most recent error (0 none, 1 bad LEN, 2 checksum, 3 timeout).
REQ-017 SHALL have port o_busy output 1: high when the FSM is not in HUNT.

Function
REQ-018 Frame format SHALL be SOF, LEN, LEN payload bytes, CSUM; CSUM = XOR of LEN and all payload bytes.
REQ-019 FSM states SHALL be HUNT, LEN, PAYLOAD, CSUM, EMIT.
REQ-020 o_rd_uart SHALL equal ~i_rx_empty in HUNT/LEN/PAYLOAD/CSUM and 0 in EMIT; at most one byte is consumed per cycle.
REQ-021 HUNT SHALL discard every consumed byte not equal to SOF without error, and go to LEN on SOF.
REQ-022 In LEN, a consumed byte of 0 or >MAX_LEN SHALL pulse o_pkt_err, set o_err_code=1, and return to HUNT; otherwise it latches LEN, seeds the checksum with LEN, and goes to PAYLOAD.
REQ-023 PAYLOAD SHALL write bytes into an internal MAX_LEN x DBITS buffer at index 0..LEN-1, XOR each byte into the checksum, and go to CSUM after byte LEN.
REQ-024 In CSUM, on the consumed byte: a match SHALL pulse o_pkt_ok the next cycle and enter EMIT; a mismatch SHALL pulse o_pkt_err, set o_err_code=2, and return to HUNT with no o_valid.
REQ-025 EMIT SHALL present buffer[idx] with o_valid=1 starting the cycle after CSUM acceptance, and advance idx on each transfer.
REQ-026 In EMIT, o_last SHALL be 1 when idx=LEN-1; that transfer returns the FSM to HUNT.
REQ-027 o_data/o_valid/o_last SHALL hold stable while o_valid & ~i_ready.
REQ-028 Timeout: a counter SHALL clear on every consumed byte and on entry to LEN, and count in LEN/PAYLOAD/CSUM while no byte is consumed.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse o_pkt_err, set o_err_code=3, and return to HUNT.
REQ-030 If a byte is consumed in the same cycle the timeout would fire, the byte SHALL win and no timeout occurs.
REQ-031 o_err_code SHALL hold until the next error; it is not cleared by good packets.
REQ-032 o_pkt_ok and o_pkt_err SHALL never be high together.
REQ-033 A new packet SHALL NOT start before EMIT completes; the RX FIFO absorbs backpressure.

Reset
REQ-034 On i_rst, the block SHALL immediately enter HUNT and zero all outputs (o_rd_uart=i_rx_empty-gated 0 during reset, o_err_code=0), counters, idx and checksum.
REQ-035 Buffer contents need not be reset.
REQ-036 A reset mid-packet SHALL discard the packet without an error pulse.

Verification
REQ-037 Good packet: A5 03 11 22 33 03 -> o_pkt_ok pulse; 11, 22, 33 transferred, o_last on 33; o_err_code stays 0.
REQ-038 Bad checksum: A5 03 11 22 33 04 -> o_pkt_err, o_err_code=2, no o_valid; a following good packet is then accepted.
REQ-039 Bad LEN: A5 00 and A5 11 (17) -> o_pkt_err, o_err_code=1 each, FSM back in HUNT.
REQ-040 Garbage: 00 FF 5A before a good packet -> bytes popped silently, packet delivered normally.
REQ-041 Timeout: A5 02 11, then FIFO empty for TIMEOUT_CYCLES -> o_pkt_err, o_err_code=3; a byte arriving exactly at the limit cycle prevents the error.
REQ-042 Backpressure/reset: i_ready=0 for 20 cycles in EMIT -> o_data stable, o_rd_uart=0 with FIFO non-empty; i_rst asserted during PAYLOAD -> outputs 0, HUNT, no pulse.
